// File: rtl/bpsk_pkg.sv
// ============================================================================
//  Module   : bpsk_pkg
//  Purpose  : Shared framing defaults and state enumeration for the BPSK
//             link blocks (data_send and packet_deframer).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bpsk_pkg;

    localparam int unsigned c_packet_size    = 16;
    localparam int unsigned c_sync_size      = 8;
    localparam logic [7:0]  c_sync_word      = 8'hA5;
    localparam int unsigned c_timeout_cycles = 64;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } deframer_state_e;

    // Width of a counter that must hold the values 0 .. n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/packet_deframer_if.sv
// ============================================================================
//  Module   : packet_deframer_if
//  Purpose  : Bit-stream input, packet handshake and status bundle of the
//             packet deframer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface packet_deframer_if #(
    parameter int unsigned PACKET_SIZE = bpsk_pkg::c_packet_size
);

    logic                   bit_in;
    logic                   bit_valid;
    logic [PACKET_SIZE-1:0] packet_out;
    logic                   packet_valid;
    logic                   packet_ready;
    logic                   locked;
    logic                   overrun;
    logic                   sync_lost;

    // Master: the receiver front end / packet consumer side.
    modport master (
        output bit_in,
        output bit_valid,
        output packet_ready,
        input  packet_out,
        input  packet_valid,
        input  locked,
        input  overrun,
        input  sync_lost
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  packet_ready,
        output packet_out,
        output packet_valid,
        output locked,
        output overrun,
        output sync_lost
    );

endinterface

`default_nettype wire

// File: rtl/packet_deframer_sync_detector.sv
// ============================================================================
//  Module   : sync_detector
//  Purpose  : Hunt shift register with saturating fill count; flags the bit
//             that completes the sync word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_detector import bpsk_pkg::*; #(
    parameter int unsigned          SYNC_SIZE = c_sync_size,
    parameter logic [SYNC_SIZE-1:0] SYNC_WORD = c_sync_word
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_shift_en,
    input  logic i_bit,
    output logic o_match
);

    localparam int unsigned        c_fill_w   = cnt_width(SYNC_SIZE + 1);
    localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(SYNC_SIZE);

    logic [SYNC_SIZE-1:0] r_shift;
    logic [SYNC_SIZE-1:0] w_shift_next;
    logic [c_fill_w-1:0]  r_fill;
    logic [c_fill_w-1:0]  w_fill_next;

    // Match is judged on the register as it will be after this bit, so the
    // completing bit is consumed here and never reaches the payload.
    always_comb begin
        w_shift_next = {r_shift[SYNC_SIZE-2:0], i_bit};
        w_fill_next  = (r_fill == c_fill_max) ? r_fill : r_fill + c_fill_w'(1);
        o_match      = i_shift_en && (w_shift_next == SYNC_WORD) && (w_fill_next == c_fill_max);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (i_shift_en) begin
            r_shift <= w_shift_next;
            r_fill  <= w_fill_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/packet_deframer.sv
// ============================================================================
//  Module   : packet_deframer
//  Purpose  : Locks onto a sync word in a serial bit stream, assembles the
//             following payload and hands it out over a valid/ready slot.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module packet_deframer import bpsk_pkg::*; #(
    parameter int unsigned          PACKET_SIZE    = c_packet_size,
    parameter int unsigned          SYNC_SIZE      = c_sync_size,
    parameter logic [SYNC_SIZE-1:0] SYNC_WORD      = c_sync_word,
    parameter int unsigned          TIMEOUT_CYCLES = c_timeout_cycles
) (
    input  logic             clock,
    input  logic             reset,
    packet_deframer_if.slave bus
);

    localparam int unsigned           c_cnt_w        = cnt_width(PACKET_SIZE);
    localparam int unsigned           c_to_w         = cnt_width(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_last_bit     = c_cnt_w'(PACKET_SIZE - 1);
    localparam logic [c_to_w-1:0]     c_timeout_last = c_to_w'(TIMEOUT_CYCLES - 1);

    deframer_state_e          r_state;
    deframer_state_e          w_state_next;
    logic [c_cnt_w-1:0]       r_bit_cnt;
    logic [c_to_w-1:0]        r_timeout_cnt;
    logic [PACKET_SIZE-1:0]   r_payload;
    logic [PACKET_SIZE-1:0]   w_payload_next;
    logic [PACKET_SIZE-1:0]   r_packet_out;
    logic                     r_packet_valid;
    logic                     r_locked;
    logic                     r_overrun;
    logic                     r_sync_lost;
    logic                     w_hunt_shift;
    logic                     w_match;
    logic                     w_complete;
    logic                     w_timeout;
    logic                     w_slot_free;
    logic                     w_load;

    sync_detector #(
        .SYNC_SIZE (SYNC_SIZE),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detector (
        .clk        (clock),
        .rst        (reset),
        .i_clear    (r_state == RECEIVE),
        .i_shift_en (w_hunt_shift),
        .i_bit      (bus.bit_in),
        .o_match    (w_match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A bit arriving in the would-be timeout cycle wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        w_hunt_shift = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            HUNT: begin
                w_hunt_shift = bus.bit_valid;
                if (w_match) begin
                    w_state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (bus.bit_valid) begin
                    if (r_bit_cnt == c_last_bit) begin
                        w_complete   = 1'b1;
                        w_state_next = HUNT;
                    end
                end else if (r_timeout_cnt == c_timeout_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = HUNT;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    // The slot counts as free when the held packet is consumed this very cycle.
    assign w_slot_free    = !r_packet_valid || bus.packet_ready;
    assign w_load         = w_complete && w_slot_free;
    assign w_payload_next = {r_payload[PACKET_SIZE-2:0], bus.bit_in};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt      <= '0;
            r_timeout_cnt  <= '0;
            r_payload      <= '0;
            r_packet_out   <= '0;
            r_packet_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_overrun      <= 1'b0;
            r_sync_lost    <= 1'b0;
        end else begin
            r_overrun   <= w_complete && !w_slot_free;
            r_sync_lost <= w_timeout;
            r_locked    <= (w_state_next == RECEIVE);

            if (r_state == RECEIVE) begin
                if (bus.bit_valid) begin
                    r_payload     <= w_payload_next;
                    r_bit_cnt     <= w_complete ? '0 : r_bit_cnt + c_cnt_w'(1);
                    r_timeout_cnt <= '0;
                end else if (w_timeout) begin
                    r_payload     <= '0;
                    r_bit_cnt     <= '0;
                    r_timeout_cnt <= '0;
                end else begin
                    r_timeout_cnt <= r_timeout_cnt + c_to_w'(1);
                end
            end else begin
                r_payload     <= '0;
                r_bit_cnt     <= '0;
                r_timeout_cnt <= '0;
            end

            if (w_load) begin
                r_packet_out   <= w_payload_next;
                r_packet_valid <= 1'b1;
            end else if (r_packet_valid && bus.packet_ready) begin
                r_packet_valid <= 1'b0;
            end
        end
    end

    assign bus.packet_out   = r_packet_out;
    assign bus.packet_valid = r_packet_valid;
    assign bus.locked       = r_locked;
    assign bus.overrun      = r_overrun;
    assign bus.sync_lost    = r_sync_lost;

endmodule

`default_nettype wire

// File: tb/tb_packet_deframer.sv
// ============================================================================
//  Module   : tb_packet_deframer
//  Purpose  : Directed scoreboard bench for packet_deframer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_packet_deframer;

    logic clock;
    logic reset;

    packet_deframer_if #(.PACKET_SIZE(16)) bus ();

    packet_deframer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          compared   = 0;
    int          mismatched = 0;
    int          n_overrun  = 0;
    int          n_sync_lost = 0;
    logic [15:0] exp_q[$];

    // Monitor: every accepted packet is popped against the scoreboard.
    always @(negedge clock) begin
        logic [15:0] exp_pkt;
        if (!reset && bus.packet_valid && bus.packet_ready) begin
            compared = compared + 1;
            if (exp_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_packet: actual %h, required no packet", bus.packet_out);
            end else begin
                exp_pkt = exp_q.pop_front();
                if (bus.packet_out !== exp_pkt) begin
                    mismatched = mismatched + 1;
                    $display("FAIL packet_data: actual %h, required %h", bus.packet_out, exp_pkt);
                end
            end
        end
        if (!reset && bus.overrun)   n_overrun   = n_overrun + 1;
        if (!reset && bus.sync_lost) n_sync_lost = n_sync_lost + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared = compared + 1;
        if (act !== req) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    // Sends v[n-1] first.
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic send_frame(input logic [15:0] p);
        send_bits(32'h0000_00A5, 8);
        send_bits({16'h0, p}, 16);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int base_ov;
        int base_sl;
        reset            = 1'b1;
        bus.bit_in       = 1'b0;
        bus.bit_valid    = 1'b0;
        bus.packet_ready = 1'b0;
        idle(2);
        check("reset_packet_out",   32'(bus.packet_out),   32'h0);
        check("reset_packet_valid", 32'(bus.packet_valid), 32'h0);
        check("reset_locked",       32'(bus.locked),       32'h0);
        check("reset_overrun",      32'(bus.overrun),      32'h0);
        check("reset_sync_lost",    32'(bus.sync_lost),    32'h0);
        reset = 1'b0;
        idle(1);

        // Noise, sync, CAFE with consumer always ready
        bus.packet_ready = 1'b1;
        send_bits(32'h5, 3);
        send_bits(32'h52, 7);
        check("lock_before_sync_end", 32'(bus.locked), 32'h0);
        send_bit(1'b1);
        check("lock_after_sync", 32'(bus.locked), 32'h1);
        exp_q.push_back(16'hCAFE);
        send_bits(32'h0000_657F, 15);
        check("valid_before_last_bit", 32'(bus.packet_valid), 32'h0);
        send_bit(1'b0);
        check("valid_after_last_bit", 32'(bus.packet_valid), 32'h1);
        check("cafe_out", 32'(bus.packet_out), 32'h0000_CAFE);
        check("unlock_after_packet", 32'(bus.locked), 32'h0);
        idle(2);

        // Overrun: slot held with 1234, BEEF dropped
        bus.packet_ready = 1'b0;
        base_ov = n_overrun;
        exp_q.push_back(16'h1234);
        send_frame(16'h1234);
        check("held_valid", 32'(bus.packet_valid), 32'h1);
        send_bits(32'h0000_00A5, 8);
        send_bits(32'h0000_5F77, 15);
        check("no_early_overrun", 32'(bus.overrun), 32'h0);
        send_bit(1'b1);
        check("overrun_pulse", 32'(bus.overrun), 32'h1);
        check("held_out_1234", 32'(bus.packet_out), 32'h0000_1234);
        idle(1);
        check("overrun_one_cycle", 32'(bus.overrun), 32'h0);
        check("overrun_count", 32'(n_overrun - base_ov), 32'h1);
        bus.packet_ready = 1'b1;
        idle(1);
        check("valid_drop_after_accept", 32'(bus.packet_valid), 32'h0);

        // Consume and reload in the same cycle
        bus.packet_ready = 1'b0;
        base_ov = n_overrun;
        exp_q.push_back(16'hCAFE);
        send_frame(16'hCAFE);
        exp_q.push_back(16'hF00D);
        send_bits(32'h0000_00A5, 8);
        send_bits(32'h0000_7806, 15);
        bus.packet_ready = 1'b1;
        send_bit(1'b1);
        bus.packet_ready = 1'b0;
        check("reload_valid", 32'(bus.packet_valid), 32'h1);
        check("reload_out", 32'(bus.packet_out), 32'h0000_F00D);
        idle(1);
        check("reload_no_overrun", 32'(n_overrun - base_ov), 32'h0);
        bus.packet_ready = 1'b1;
        idle(2);

        // Timeout after 5 payload bits
        base_sl = n_sync_lost;
        send_bits(32'h0000_00A5, 8);
        send_bits(32'h0000_0015, 5);
        idle(63);
        check("no_timeout_at_63", 32'(bus.sync_lost), 32'h0);
        check("locked_at_63", 32'(bus.locked), 32'h1);
        idle(1);
        check("timeout_pulse", 32'(bus.sync_lost), 32'h1);
        check("timeout_unlock", 32'(bus.locked), 32'h0);
        check("timeout_no_valid", 32'(bus.packet_valid), 32'h0);
        idle(1);
        check("timeout_count", 32'(n_sync_lost - base_sl), 32'h1);
        exp_q.push_back(16'h00FF);
        send_frame(16'h00FF);
        check("after_timeout_out", 32'(bus.packet_out), 32'h0000_00FF);
        idle(2);

        // Bit arriving in the timeout cycle is accepted instead
        base_sl = n_sync_lost;
        send_bits(32'h0000_00A5, 8);
        idle(63);
        exp_q.push_back(16'h9ABC);
        send_bit(1'b1);
        check("bit_beats_timeout_lock", 32'(bus.locked), 32'h1);
        send_bits(32'h0000_1ABC, 15);
        check("bit_beats_timeout_out", 32'(bus.packet_out), 32'h0000_9ABC);
        check("bit_beats_timeout_nosl", 32'(n_sync_lost - base_sl), 32'h0);
        idle(2);

        // Reset at payload bit 9
        base_ov = n_overrun;
        base_sl = n_sync_lost;
        send_bits(32'h0000_00A5, 8);
        send_bits(32'h0000_0013, 8);
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b1;
        reset         = 1'b1;
        @(posedge clock);
        #1;
        reset         = 1'b0;
        bus.bit_valid = 1'b0;
        check("midreset_out",    32'(bus.packet_out),   32'h0);
        check("midreset_valid",  32'(bus.packet_valid), 32'h0);
        check("midreset_locked", 32'(bus.locked),       32'h0);
        check("midreset_ov",     32'(bus.overrun),      32'h0);
        check("midreset_sl",     32'(bus.sync_lost),    32'h0);
        send_bits(32'h0000_0057, 7);
        idle(3);
        check("midreset_no_packet", 32'(bus.packet_valid), 32'h0);
        check("midreset_no_lock", 32'(bus.locked), 32'h0);
        check("midreset_no_pulses", 32'((n_overrun - base_ov) + (n_sync_lost - base_sl)), 32'h0);

        // Partial sync right after reset must not lock
        pulse_reset();
        send_bits(32'h0000_0025, 7);
        check("partial_sync_7", 32'(bus.locked), 32'h0);
        send_bit(1'b1);
        check("partial_sync_8", 32'(bus.locked), 32'h0);
        send_bits(32'h0000_0052, 7);
        check("resync_7", 32'(bus.locked), 32'h0);
        send_bit(1'b1);
        check("resync_8", 32'(bus.locked), 32'h1);
        exp_q.push_back(16'h0001);
        send_bits(32'h0000_0001, 16);
        check("final_out", 32'(bus.packet_out), 32'h0000_0001);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            idle(1);
        end
        idle(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/packet_deframer.md
PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 SHALL take parameter PACKET_SIZE, default 16; payload bits per packet.
REQ-002 SHALL take parameter SYNC_SIZE, default 8; sync word length in bits.
REQ-003 SHALL take parameter SYNC_WORD, default 8'hA5; preamble preceding every payload, MSB first.
REQ-004 SHALL take parameter TIMEOUT_CYCLES, default 64; maximum clock cycles between bits while locked.
REQ-005 SHALL have port clock, input, 1 bit; single system clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-007 SHALL have port bit_in, input, 1 bit; demodulated bit from the receiver stage.
REQ-008 SHALL have port bit_valid, input, 1 bit; one-cycle strobe qualifying bit_in.
REQ-009 SHALL have port packet_out, output, PACKET_SIZE bits; assembled payload, first received bit in MSB.
REQ-010 SHALL have port packet_valid, output, 1 bit; packet_out holds an unconsumed packet.
REQ-011 SHALL have port packet_ready, input, 1 bit; consumer accepts packet_out this cycle.
REQ-012 SHALL have port locked, output, 1 bit; high while in RECEIVE.
REQ-013 SHALL have port overrun, output, 1 bit; one-cycle pulse when a completed packet is dropped.
REQ-014 SHALL have port sync_lost, output, 1 bit; one-cycle pulse on bit-gap timeout.

Function
REQ-015 SHALL implement states HUNT and RECEIVE; HUNT after reset.
REQ-016 In HUNT, each bit_valid SHALL shift bit_in into a SYNC_SIZE-bit register at the LSB and increment a saturating fill count.
REQ-017 Match SHALL be declared when the post-shift register equals SYNC_WORD and fill count, including that bit, is at least SYNC_SIZE; transition to RECEIVE on the next edge, clearing bit count and timeout counter.
REQ-018 The bit that completes the sync match SHALL NOT be part of the payload; the first payload bit is the next bit_valid.
REQ-019 In RECEIVE, each bit_valid SHALL shift bit_in into the payload register, MSB first, and increment the bit count from 0 to PACKET_SIZE-1.
REQ-020 On the PACKET_SIZE-th payload bit, SHALL return to HUNT with hunt register and fill count cleared.
REQ-021 If the output slot is free (packet_valid low, or packet_valid and packet_ready both high) in the completion cycle, SHALL load packet_out and assert packet_valid on the next cycle.
REQ-022 Otherwise SHALL drop the new packet, hold packet_out unchanged, and pulse overrun for one cycle.
REQ-023 packet_valid SHALL stay high and packet_out stable until sampled with packet_ready high; then packet_valid SHALL fall on the next edge unless REQ-021 reloads in the same cycle.
REQ-024 In RECEIVE, the timeout counter SHALL clear on bit_valid and increment otherwise.
REQ-025 On reaching TIMEOUT_CYCLES, SHALL pulse sync_lost, discard the partial payload, and enter HUNT with hunt state cleared.
REQ-026 A bit_valid in the timeout cycle SHALL take priority: no timeout, bit accepted.
REQ-027 locked SHALL equal (state == RECEIVE), registered.
REQ-028 packet_ready SHALL be ignored while packet_valid is low.

Reset
REQ-029 Reset SHALL force state HUNT, packet_out 0, packet_valid 0, locked 0, overrun 0, sync_lost 0, and clear all counters and shift registers.
REQ-030 Reset mid-RECEIVE SHALL discard partial data without pulsing sync_lost or overrun.
REQ-031 Reset SHALL override every other input in the same cycle.

Structure
REQ-032 PACKET_SIZE, SYNC_SIZE, SYNC_WORD, TIMEOUT_CYCLES defaults and the state enumeration SHALL live in shared package bpsk_pkg, used by data_send and this block.
REQ-033 Sync comparison (hunt shift register, fill count, match) SHALL be a sub-module sync_detector; the remainder stays in packet_deframer.

Verification
REQ-034 Send bits 1,0,1 as noise, then 8'hA5, then 16'hCAFE with packet_ready high -> packet_out=16'hCAFE, packet_valid high exactly one cycle after the 16th bit_valid, locked low after completion.
REQ-035 packet_ready low; send two framed packets 16'h1234 and 16'hBEEF -> packet_out holds 16'h1234, overrun pulses once at the 16th bit of the second packet.
REQ-036 Sync, 5 payload bits, then 64 idle cycles -> sync_lost pulses once, locked falls, no packet_valid; a subsequent A5+16'h00FF frame yields 16'h00FF.
REQ-037 Assert reset for 1 cycle at payload bit 9 of a frame -> all outputs 0 next cycle, no pulses, and the remaining bits produce no packet.
REQ-038 packet_valid high with 16'hCAFE; packet_ready high in the same cycle a second packet 16'hF00D completes -> no overrun, packet_valid stays high, packet_out=16'hF00D.
REQ-039 Feed 7 bits 0100101 then 1 (only 7 bits after reset before the match) -> no lock until a full 8-bit A5 has been shifted.
